// File: rtl/sfr_mt_pkg.sv
// Shared register map, timer layout and control struct for the multi-timer SFR block.
package sfr_mt_pkg;

    localparam logic [7:0] REG_IDCODE      = 8'h00;
    localparam logic [7:0] REG_CTRL        = 8'h04;
    localparam logic [7:0] REG_CORENUM     = 8'h08;
    localparam logic [7:0] REG_IRQ_EN      = 8'h10;
    localparam logic [7:0] REG_SGI         = 8'h14;
    localparam logic [7:0] REG_TSTATUS     = 8'h18;
    localparam logic [7:0] REG_TSTATUS_SET = 8'h1C;

    localparam logic [7:0] TIMER_BASE   = 8'h40;
    localparam logic [7:0] TIMER_STRIDE = 8'h10;
    localparam logic [3:0] TREG_CTRL    = 4'h0;
    localparam logic [3:0] TREG_PERIOD  = 4'h4;
    localparam logic [3:0] TREG_VALUE   = 4'h8;

    localparam logic [31:0] IDCODE = 32'hdeadbeef;

    // presc is held at its widest legal size; bits above PRESC_WIDTH stay zero
    localparam int PRESC_MAX = 16;

    typedef struct packed {
        logic [PRESC_MAX-1:0] presc;
        logic                 irq_en;
        logic                 reload;
        logic                 en;
    } tctrl_t;

    function automatic logic [3:0] timer_idx(input logic [7:0] a);
        return 4'((a - TIMER_BASE) / TIMER_STRIDE);
    endfunction

endpackage

// File: rtl/MemSplit32.sv
// Split request/response 32-bit register bus used on the sigma tile.
interface MemSplit32;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport Slave  (input req, we, addr, wdata, output ack, resp, rdata);
    modport Master (output req, we, addr, wdata, input ack, resp, rdata);
endinterface

// File: rtl/sfr_mt_timer.sv
// One prescaled timer channel: control, period, counter and prescaler state.
module sfr_timer
    import sfr_mt_pkg::*;
#(
    parameter int TIMER_WIDTH = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   cfg_we_i,
    input  logic                   period_we_i,
    input  logic [31:0]            wdata_i,
    output tctrl_t                 tctrl_o,
    output logic [TIMER_WIDTH-1:0] period_o,
    output logic [TIMER_WIDTH-1:0] value_o,
    output logic                   expire_o
);

    tctrl_t                 tctrl_q;
    tctrl_t                 cfg_wr;
    logic [TIMER_WIDTH-1:0] period_q;
    logic [TIMER_WIDTH-1:0] value_q;
    logic [TIMER_WIDTH-1:0] value_inc;
    logic [PRESC_WIDTH-1:0] pcnt_q;
    logic                   tick;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata_i;

    always_comb begin
        cfg_wr        = '0;
        cfg_wr.en     = wdata_i[0];
        cfg_wr.reload = wdata_i[1];
        cfg_wr.irq_en = wdata_i[2];
        cfg_wr.presc  = PRESC_MAX'(wdata_i[8 +: PRESC_WIDTH]);
    end

    assign tick      = tctrl_q.en && (pcnt_q == tctrl_q.presc[PRESC_WIDTH-1:0]);
    assign value_inc = value_q + TIMER_WIDTH'(1);
    // PERIOD=0 naturally expires on the wrap because value_inc truncates
    assign expire_o  = tick && (value_inc == period_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tctrl_q  <= '0;
            period_q <= '0;
            value_q  <= '0;
            pcnt_q   <= '0;
        end else if (clear_i) begin
            tctrl_q  <= '0;
            period_q <= '0;
            value_q  <= '0;
            pcnt_q   <= '0;
        end else begin
            if (period_we_i) period_q <= wdata_i[TIMER_WIDTH-1:0];
            if (cfg_we_i) begin
                tctrl_q <= cfg_wr;
                value_q <= '0;
                pcnt_q  <= '0;
            end else if (tctrl_q.en) begin
                pcnt_q <= tick ? '0 : pcnt_q + PRESC_WIDTH'(1);
                if (expire_o) begin
                    value_q    <= '0;
                    tctrl_q.en <= tctrl_q.reload;
                end else if (tick) begin
                    value_q <= value_inc;
                end
            end
        end
    end

    assign tctrl_o  = tctrl_q;
    assign period_o = period_q;
    assign value_o  = value_q;

endmodule

// File: rtl/sfr_mt.sv
// Multi-timer SFR: bus decode, common registers, sticky timer status and IRQ outputs.
module sfr_mt
    import sfr_mt_pkg::*;
#(
    parameter int CORENUM          = 0,
    parameter bit SW_RESET_DEFAULT = 1'b0,
    parameter int IRQ_NUM_POW      = 4,
    parameter int TIMER_NUM        = 4,
    parameter int TIMER_WIDTH      = 32,
    parameter int PRESC_WIDTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    MemSplit32.Slave                    host,
    output logic                        sw_reset_o,
    output logic [2**IRQ_NUM_POW-1:0]   irq_en_bo,
    output logic                        sgi_req_o,
    output logic [IRQ_NUM_POW-1:0]      sgi_code_bo,
    output logic [TIMER_NUM-1:0]        irq_timer_bo,
    output logic                        irq_timer_o
);

    localparam int IRQ_W = 2**IRQ_NUM_POW;

    logic [7:0]             a;
    logic [3:0]             tidx;
    logic [3:0]             toff;
    logic                   wr, rd, tsel;
    logic                   unused_ok;

    logic                   sw_reset_q, autoclr_q, sw_rst_out_q;
    logic [IRQ_W-1:0]       irq_en_q;
    logic                   sgi_req_q;
    logic [IRQ_NUM_POW-1:0] sgi_code_q;
    logic [TIMER_NUM-1:0]   status_q, status_d;
    logic                   resp_q;
    logic [31:0]            rdata_q, rdata_d;

    tctrl_t                 tctrl  [TIMER_NUM];
    logic [TIMER_WIDTH-1:0] period [TIMER_NUM];
    logic [TIMER_WIDTH-1:0] value  [TIMER_NUM];
    logic [TIMER_NUM-1:0]   expire;

    assign a         = host.addr[7:0];
    assign wr        = host.req && host.we;
    assign rd        = host.req && !host.we;
    assign tidx      = timer_idx(a);
    assign toff      = a[3:0];
    assign tsel      = (a >= TIMER_BASE) && (32'(tidx) < 32'(TIMER_NUM));
    assign unused_ok = ^{host.addr[31:8], host.wdata};

    for (genvar gi = 0; gi < TIMER_NUM; gi++) begin : g_tmr
        logic hit;
        assign hit = wr && tsel && (tidx == 4'(gi));

        sfr_timer #(
            .TIMER_WIDTH(TIMER_WIDTH),
            .PRESC_WIDTH(PRESC_WIDTH)
        ) u_tmr (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .clear_i     (sw_rst_out_q),
            .cfg_we_i    (hit && (toff == TREG_CTRL)),
            .period_we_i (hit && (toff == TREG_PERIOD)),
            .wdata_i     (host.wdata),
            .tctrl_o     (tctrl[gi]),
            .period_o    (period[gi]),
            .value_o     (value[gi]),
            .expire_o    (expire[gi])
        );

        assign irq_timer_bo[gi] = status_q[gi] && tctrl[gi].irq_en;
    end

    // Hardware expiry is applied after W1C so a same-cycle set wins
    always_comb begin
        status_d = status_q;
        if (wr && a == REG_TSTATUS)     status_d = status_d & ~host.wdata[TIMER_NUM-1:0];
        if (wr && a == REG_TSTATUS_SET) status_d = status_d | host.wdata[TIMER_NUM-1:0];
        status_d = status_d | expire;
        if (sw_rst_out_q) status_d = '0;
    end

    always_comb begin
        rdata_d = '0;
        if (tsel) begin
            for (int n = 0; n < TIMER_NUM; n++) begin
                if (tidx == 4'(n)) begin
                    case (toff)
                        TREG_CTRL:   rdata_d = {8'h0, tctrl[n].presc, 5'h0,
                                                tctrl[n].irq_en, tctrl[n].reload, tctrl[n].en};
                        TREG_PERIOD: rdata_d = 32'(period[n]);
                        TREG_VALUE:  rdata_d = 32'(value[n]);
                        default:     rdata_d = '0;
                    endcase
                end
            end
        end else begin
            case (a)
                REG_IDCODE:  rdata_d = IDCODE;
                REG_CTRL:    rdata_d = {30'h0, autoclr_q, sw_reset_q};
                REG_CORENUM: rdata_d = 32'(CORENUM);
                REG_IRQ_EN:  rdata_d = 32'(irq_en_q);
                REG_SGI:     rdata_d = 32'(sgi_code_q);
                REG_TSTATUS: rdata_d = 32'(status_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_reset_q   <= SW_RESET_DEFAULT;
            autoclr_q    <= 1'b0;
            sw_rst_out_q <= 1'b1;
            irq_en_q     <= '0;
            sgi_req_q    <= 1'b0;
            sgi_code_q   <= '0;
            status_q     <= '0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            sw_rst_out_q <= sw_reset_q;
            if (wr && a == REG_CTRL) begin
                sw_reset_q <= host.wdata[0];
                autoclr_q  <= host.wdata[1];
            end else if (sw_reset_q && autoclr_q) begin
                sw_reset_q <= 1'b0;
            end
            if (wr && a == REG_IRQ_EN) irq_en_q <= host.wdata[IRQ_W-1:0];
            sgi_req_q <= wr && (a == REG_SGI);
            if (wr && a == REG_SGI) sgi_code_q <= host.wdata[IRQ_NUM_POW-1:0];
            status_q <= status_d;
            resp_q   <= rd;
            rdata_q  <= rd ? rdata_d : '0;
        end
    end

    assign host.ack    = host.req;
    assign host.resp   = resp_q;
    assign host.rdata  = rdata_q;
    assign sw_reset_o  = sw_rst_out_q;
    assign irq_en_bo   = irq_en_q;
    assign sgi_req_o   = sgi_req_q;
    assign sgi_code_bo = sgi_code_q;
    assign irq_timer_o = |irq_timer_bo;

endmodule

// File: tb/tb_sfr_mt.sv
// Directed bench for sfr_mt: register map, timer timing, status conflicts, sw reset and SGI.
module tb_sfr_mt;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sw_reset_o;
    logic [15:0] irq_en_bo;
    logic        sgi_req_o;
    logic [3:0]  sgi_code_bo;
    logic [3:0]  irq_timer_bo;
    logic        irq_timer_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    MemSplit32 host_if();

    sfr_mt #(
        .CORENUM          (3),
        .SW_RESET_DEFAULT (1'b0),
        .IRQ_NUM_POW      (4),
        .TIMER_NUM        (4),
        .TIMER_WIDTH      (8),
        .PRESC_WIDTH      (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .host         (host_if),
        .sw_reset_o   (sw_reset_o),
        .irq_en_bo    (irq_en_bo),
        .sgi_req_o    (sgi_req_o),
        .sgi_code_bo  (sgi_code_bo),
        .irq_timer_bo (irq_timer_bo),
        .irq_timer_o  (irq_timer_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk_i);
        host_if.req   = 1'b1;
        host_if.we    = 1'b1;
        host_if.addr  = {24'h0, a};
        host_if.wdata = d;
        @(negedge clk_i);
        host_if.req = 1'b0;
        host_if.we  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk_i);
        host_if.req  = 1'b1;
        host_if.we   = 1'b0;
        host_if.addr = {24'h0, a};
        @(negedge clk_i);
        host_if.req = 1'b0;
        chk({tag, "_resp"}, 32'(host_if.resp), 32'h1);
        chk(tag, host_if.rdata, exp);
    endtask

    initial begin
        host_if.req   = 1'b0;
        host_if.we    = 1'b0;
        host_if.addr  = '0;
        host_if.wdata = '0;

        // reset
        repeat (3) @(negedge clk_i);
        chk("rst_resp",  32'(host_if.resp), 32'h0);
        chk("rst_rdata", host_if.rdata, 32'h0);
        rst_ni = 1'b1;
        chk("rst_swrst_first", 32'(sw_reset_o), 32'h1);
        chk("rst_irq_timer",   32'(irq_timer_bo), 32'h0);
        chk("rst_irq_or",      32'(irq_timer_o), 32'h0);
        chk("rst_irq_en",      32'(irq_en_bo), 32'h0);
        chk("rst_sgi",         32'(sgi_req_o), 32'h0);
        @(negedge clk_i);
        chk("rst_swrst_after", 32'(sw_reset_o), 32'h0);

        rd("idcode",   8'h00, 32'hdeadbeef);
        rd("corenum",  8'h08, 32'h3);
        rd("unmapped", 8'h0C, 32'h0);
        rd("tmr5_unmapped", 8'h90, 32'h0);

        // back-to-back reads, one resp per req in order
        @(negedge clk_i);
        host_if.req  = 1'b1;
        host_if.we   = 1'b0;
        host_if.addr = 32'h0;
        #1 chk("ack_comb", 32'(host_if.ack), 32'h1);
        @(negedge clk_i);
        chk("b2b_resp0",  32'(host_if.resp), 32'h1);
        chk("b2b_rdata0", host_if.rdata, 32'hdeadbeef);
        host_if.addr = 32'h8;
        @(negedge clk_i);
        chk("b2b_resp1",  32'(host_if.resp), 32'h1);
        chk("b2b_rdata1", host_if.rdata, 32'h3);
        host_if.req = 1'b0;
        @(negedge clk_i);
        chk("b2b_resp_idle", 32'(host_if.resp), 32'h0);

        // timer 0 one-shot, PERIOD=5, presc 0: IRQ 6 cycles after TCTRL write
        wr(8'h44, 32'h5);
        wr(8'h40, 32'h5);
        chk("t0_irq_early", 32'(irq_timer_bo[0]), 32'h0);
        repeat (4) @(negedge clk_i);
        chk("t0_irq_c5", 32'(irq_timer_bo[0]), 32'h0);
        @(negedge clk_i);
        chk("t0_irq_c6", 32'(irq_timer_bo[0]), 32'h1);
        chk("t0_irq_or", 32'(irq_timer_o), 32'h1);
        repeat (3) @(negedge clk_i);
        chk("t0_irq_held", 32'(irq_timer_bo[0]), 32'h1);
        rd("t0_value", 8'h48, 32'h0);
        rd("t0_tctrl", 8'h40, 32'h4);
        rd("t0_status", 8'h18, 32'h1);
        wr(8'h18, 32'h1);
        chk("t0_w1c_irq", 32'(irq_timer_bo[0]), 32'h0);

        // timer 1: presc 3, PERIOD 2, reload -> expiry every 8 cycles
        wr(8'h54, 32'h2);
        wr(8'h50, 32'h307);
        repeat (7) @(negedge clk_i);
        chk("t1_irq_c8", 32'(irq_timer_bo[1]), 32'h0);
        @(negedge clk_i);
        chk("t1_irq_c9", 32'(irq_timer_bo[1]), 32'h1);
        wr(8'h18, 32'h2);
        chk("t1_w1c", 32'(irq_timer_bo[1]), 32'h0);
        repeat (5) @(negedge clk_i);
        chk("t1_irq_c16", 32'(irq_timer_bo[1]), 32'h0);
        @(negedge clk_i);
        chk("t1_irq_c17", 32'(irq_timer_bo[1]), 32'h1);
        repeat (10) @(negedge clk_i);
        chk("t1_sticky", 32'(irq_timer_bo[1]), 32'h1);
        wr(8'h50, 32'h303);
        chk("t1_irq_masked", 32'(irq_timer_bo[1]), 32'h0);
        rd("t1_status", 8'h18, 32'h2);

        // timer 2: W1C lands in the expiry cycle, set must win
        wr(8'h64, 32'h3);
        wr(8'h60, 32'h1);
        @(negedge clk_i);
        wr(8'h18, 32'h4);
        rd("t2_conflict", 8'h18, 32'h6);

        // timer 3: 8-bit counter, PERIOD 0 wraps after 256 ticks
        wr(8'h74, 32'h0);
        wr(8'h70, 32'h5);
        repeat (255) @(negedge clk_i);
        chk("t3_wrap_c256", 32'(irq_timer_bo[3]), 32'h0);
        @(negedge clk_i);
        chk("t3_wrap_c257", 32'(irq_timer_bo[3]), 32'h1);
        chk("irq_vec", 32'(irq_timer_bo), 32'h8);

        // software reset with autoclr while timer 1 runs
        wr(8'h10, 32'hA5A5);
        chk("irq_en_out", 32'(irq_en_bo), 32'hA5A5);
        wr(8'h04, 32'h3);
        chk("swrst_c1", 32'(sw_reset_o), 32'h0);
        @(negedge clk_i);
        chk("swrst_c2", 32'(sw_reset_o), 32'h1);
        @(negedge clk_i);
        chk("swrst_c3", 32'(sw_reset_o), 32'h0);
        rd("swrst_t1_value",  8'h58, 32'h0);
        rd("swrst_t1_tctrl",  8'h50, 32'h0);
        rd("swrst_t1_period", 8'h54, 32'h0);
        rd("swrst_t3_tctrl",  8'h70, 32'h0);
        rd("swrst_status",    8'h18, 32'h0);
        rd("swrst_irq_en",    8'h10, 32'hA5A5);
        rd("swrst_ctrl",      8'h04, 32'h2);
        chk("swrst_irq_or", 32'(irq_timer_o), 32'h0);

        // SGI strobe
        wr(8'h14, 32'h7);
        chk("sgi_req",  32'(sgi_req_o), 32'h1);
        chk("sgi_code", 32'(sgi_code_bo), 32'h7);
        @(negedge clk_i);
        chk("sgi_req_drop", 32'(sgi_req_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
